// File: rtl/alu_op_issue_pkg.sv
// Shared opcode/funct constants and types for the ID-stage ALU op issue slice.
// Latency: none (constants and helpers only).
// Backpressure: n/a.
package alu_op_issue_pkg;

  localparam int OP_W_DEF    = 6;
  localparam int FUNCT_W_DEF = 6;
  localparam int MD_CNT_W    = 8;

  // Opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // ALU / special funct codes
  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Occupancy load value, clamped to the 1..255 range the counter supports.
  function automatic logic [MD_CNT_W-1:0] md_load(input int cycles);
    if (cycles < 1)        return MD_CNT_W'(1);
    else if (cycles > 255) return MD_CNT_W'(255);
    else                   return MD_CNT_W'(cycles);
  endfunction

endpackage

// File: rtl/alu_op_issue_funct_map.sv
// Pure combinational {op, funct_in} -> ALU funct code + illegal flag table.
// Latency: combinational, zero cycles.
// Backpressure: none; callers own all handshaking.
// Ports: op/funct_in (instruction fields) in; funct/illegal (mapped code, unmapped-op flag) out.
module alu_op_issue_funct_map
  import alu_op_issue_pkg::*;
#(
  parameter int OP_W    = OP_W_DEF,
  parameter int FUNCT_W = FUNCT_W_DEF
) (
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  output logic [FUNCT_W-1:0] funct,
  output logic               illegal
);

  always_comb begin
    funct   = FUNCT_W'(FN_NOP);
    illegal = 1'b0;
    case (op)
      OP_W'(OP_SPECIAL): funct = funct_in;
      OP_W'(OP_ADDI):    funct = FUNCT_W'(FN_ADD);
      OP_W'(OP_ADDIU),
      OP_W'(OP_LB), OP_W'(OP_LH), OP_W'(OP_LW), OP_W'(OP_LBU), OP_W'(OP_LHU),
      OP_W'(OP_SB), OP_W'(OP_SH), OP_W'(OP_SW):
                         funct = FUNCT_W'(FN_ADDU);
      OP_W'(OP_SLTI):    funct = FUNCT_W'(FN_SLT);
      OP_W'(OP_SLTIU):   funct = FUNCT_W'(FN_SLTU);
      OP_W'(OP_ANDI):    funct = FUNCT_W'(FN_AND);
      OP_W'(OP_ORI),
      OP_W'(OP_LUI),
      OP_W'(OP_JAL):     funct = FUNCT_W'(FN_OR);
      OP_W'(OP_XORI):    funct = FUNCT_W'(FN_XOR);
      default: begin
        funct   = FUNCT_W'(FN_NOP);
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_issue.sv
// ID/EX funct register: maps decoded ops to ALU funct codes and tracks MULT/DIV occupancy.
// Latency: one cycle from accept to out_valid/funct_out.
// Backpressure: in_ready drops when the slot is full and not draining, under flush, or when
//   a HI/LO reader or new mult/div meets a busy mult/div unit; funct_out holds while stalled.
// Ports: clk/rst (sync, active-high), flush; in_valid/in_ready/op/funct_in from decoder;
//   out_valid/out_ready/funct_out/illegal to EX; md_busy/md_done occupancy status.
module alu_op_issue
  import alu_op_issue_pkg::*;
#(
  parameter int OP_W        = OP_W_DEF,
  parameter int FUNCT_W     = FUNCT_W_DEF,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter bit MD_ENABLE   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FUNCT_W-1:0] funct_out,
  output logic               illegal,
  output logic               md_busy,
  output logic               md_done
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = md_load(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = md_load(DIV_CYCLES);

  logic [FUNCT_W-1:0]  map_funct;
  logic                map_illegal;
  md_state_t           state;
  logic [MD_CNT_W-1:0] md_cnt;

  logic is_special;
  logic is_mult;
  logic is_div;
  logic is_hilo;
  logic md_haz;
  logic accept;

  alu_op_issue_funct_map #(
    .OP_W    (OP_W),
    .FUNCT_W (FUNCT_W)
  ) u_funct_map (
    .op       (op),
    .funct_in (funct_in),
    .funct    (map_funct),
    .illegal  (map_illegal)
  );

  assign is_special = (op == OP_W'(OP_SPECIAL));
  assign is_mult    = is_special && ((funct_in == FUNCT_W'(FN_MULT)) ||
                                     (funct_in == FUNCT_W'(FN_MULTU)));
  assign is_div     = is_special && ((funct_in == FUNCT_W'(FN_DIV)) ||
                                     (funct_in == FUNCT_W'(FN_DIVU)));
  assign is_hilo    = is_special && ((funct_in == FUNCT_W'(FN_MFHI)) ||
                                     (funct_in == FUNCT_W'(FN_MFLO)));

  assign md_busy  = (state == MD_BUSY);
  assign md_haz   = md_busy && (is_mult || is_div || is_hilo);
  // flush forces in_ready low, so a flush and an accept never share a cycle.
  assign in_ready = !flush && !md_haz && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // ID/EX handshake register. funct_out/illegal only change on accept, so they stay
  // stable for the whole stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      funct_out <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      funct_out <= map_funct;
      illegal   <= map_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Mult/div occupancy. Flush is deliberately ignored: the EX unit finishes the
  // operation regardless, so HI/LO stay unavailable until the count expires.
  // md_done is registered one cycle early so it is high exactly while md_cnt==1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MD_IDLE;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          md_done <= 1'b0;
          if (MD_ENABLE && accept && is_mult) begin
            state   <= MD_BUSY;
            md_cnt  <= MULT_LOAD;
            md_done <= (MULT_LOAD == MD_CNT_W'(1));
          end else if (MD_ENABLE && accept && is_div) begin
            state   <= MD_BUSY;
            md_cnt  <= DIV_LOAD;
            md_done <= (DIV_LOAD == MD_CNT_W'(1));
          end
        end
        MD_BUSY: begin
          // Saturating decrement; the counter never wraps below zero.
          md_cnt  <= (md_cnt > MD_CNT_W'(1)) ? md_cnt - MD_CNT_W'(1) : '0;
          md_done <= (md_cnt == MD_CNT_W'(2));
          if (md_cnt <= MD_CNT_W'(1)) begin
            state <= MD_IDLE;
          end
        end
        default: begin
          state   <= MD_IDLE;
          md_cnt  <= '0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
